// File: rtl/oled_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_tx
// Purpose  : Byte-wide SPI mode-3 serializer with D/C line for an OLED panel.
// Revision : 1.0
// ============================================================================
module oled_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_isData,
    output logic       oled_clk,
    output logic       oled_dout,
    output logic       oled_isData,
    output logic       tx_done
);

    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          sclk_q;
    logic          dout_q;
    logic          isd_q;
    logic          done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b1;
            dout_q  <= 1'b0;
            isd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= 1'b1;
                    if (in_valid) begin
                        // Bit 7 goes out with the falling SCLK at accept; the rest queue in shreg_q.
                        state_q <= SHIFT;
                        isd_q   <= in_isData;
                        dout_q  <= in_data[7];
                        shreg_q <= {in_data[6:0], 1'b0};
                        bit_q   <= 3'd7;
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DW'(1);
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bit_q == 3'd0) begin
                            // End of bit 0 high phase: SCLK stays high into IDLE.
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            sclk_q  <= 1'b0;
                            dout_q  <= shreg_q[7];
                            shreg_q <= {shreg_q[6:0], 1'b0};
                            bit_q   <= bit_q - 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign oled_clk    = sclk_q;
    assign oled_dout   = dout_q;
    assign oled_isData = isd_q;
    assign tx_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_spi_tx
// Purpose  : Scoreboard bench for oled_spi_tx at CLK_DIV=4 (inst 0) and 1 (inst 1).
// Revision : 1.0
// ============================================================================
module tb_oled_spi_tx;

    typedef struct packed {
        logic [7:0]  d;
        logic        isd;
        logic [31:0] t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_data [2];
    logic [1:0] in_isData;
    logic [1:0] oled_clk;
    logic [1:0] oled_dout;
    logic [1:0] oled_isData;
    logic [1:0] tx_done;
    int         cyc;
    int         pend [2];
    int         n_vec;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : 1;

        oled_spi_tx #(.CLK_DIV(D)) u_dut (
            .clock       (clk),
            .reset       (rst),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_data     (in_data[g]),
            .in_isData   (in_isData[g]),
            .oled_clk    (oled_clk[g]),
            .oled_dout   (oled_dout[g]),
            .oled_isData (oled_isData[g]),
            .tx_done     (tx_done[g])
        );

        exp_t       q [$];
        exp_t       e;
        logic [7:0] sh;
        int         nb;
        logic       ps, pd, acc_pend, acc_isd;

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                nb = 0; ps = 1'b1; pd = 1'b0; acc_pend = 1'b0; sh = 8'h00;
            end else begin
                if (acc_pend) begin
                    chk("isd_after_accept", oled_isData[g], acc_isd);
                    acc_pend = 1'b0;
                end
                if (oled_dout[g] !== pd && !(ps && !oled_clk[g]))
                    chk("dout_change_off_fall", oled_dout[g], pd);
                if (!ps && oled_clk[g]) begin
                    sh = {sh[6:0], oled_dout[g]};
                    nb++;
                end
                if (tx_done[g]) begin
                    if (q.size() == 0) begin
                        chk("spurious_tx_done", tx_done[g], 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("byte", sh, e.d);
                        chk("sclk_rises", nb, 8);
                        chk("done_latency", cyc - e.t, 16 * D + 1);
                        chk("isd_at_done", oled_isData[g], e.isd);
                    end
                    nb = 0;
                end
                if (in_ready[g]) chk("sclk_idle_high", oled_clk[g], 1'b1);
                if (q.size() > 0) chk("ready_low_in_shift", in_ready[g], 1'b0);
                if (in_valid[g] && in_ready[g]) begin
                    q.push_back('{d: in_data[g], isd: in_isData[g], t: cyc});
                    acc_pend = 1'b1;
                    acc_isd  = in_isData[g];
                end
                ps = oled_clk[g];
                pd = oled_dout[g];
            end
            pend[g] = q.size();
        end
    end

    task automatic send(input int g, input logic [7:0] d, input logic isd,
                        input bit hold, output int t);
        int n;
        n = 0;
        in_valid[g]  = 1'b1;
        in_data[g]   = d;
        in_isData[g] = isd;
        while (!in_ready[g] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("accept_timeout", 32'(n), 0);
        t = cyc;
        @(posedge clk); #1;
        if (!hold) in_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (pend[g] != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(pend[g]), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input int g);
        chk("rst_sclk",  oled_clk[g],    1'b1);
        chk("rst_dout",  oled_dout[g],   1'b0);
        chk("rst_isd",   oled_isData[g], 1'b0);
        chk("rst_ready", in_ready[g],    1'b1);
        chk("rst_done",  tx_done[g],     1'b0);
    endtask

    initial begin
        int t1, t2, n;
        n_vec = 0; n_err = 0;
        pend[0] = 0; pend[1] = 0;
        rst = 1'b1;
        in_valid = '0; in_isData = '0;
        in_data[0] = 8'h00; in_data[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst = 1'b0;

        send(0, 8'hA5, 1'b0, 1'b0, t1);
        wait_idle(0);

        send(0, 8'hFF, 1'b1, 1'b1, t1);
        send(0, 8'h00, 1'b0, 1'b0, t2);
        chk("b2b_period", t2 - t1, 65);
        wait_idle(0);

        send(1, 8'h3C, 1'b0, 1'b0, t1);
        wait_idle(1);
        send(1, 8'hC3, 1'b1, 1'b1, t1);
        send(1, 8'h96, 1'b0, 1'b0, t2);
        chk("b2b_period_div1", t2 - t1, 17);
        wait_idle(1);

        send(0, 8'h5A, 1'b1, 1'b0, t1);
        n = 0;
        while (!in_ready[0] && n < 300) begin
            in_valid[0]  = 1'($urandom);
            in_data[0]   = 8'($urandom);
            in_isData[0] = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid[0] = 1'b0;
        wait_idle(0);

        send(0, 8'h81, 1'b1, 1'b0, t1);
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 8'h42, 1'b1, 1'b0, t2);
        chk("first_edge_accept", in_ready[0], 1'b0);
        wait_idle(0);

        repeat (100) @(posedge clk);
        #1;
        chk("idle_sclk", oled_clk[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
